jtdd_sdram_resp: RTL and testbench

- Responder end of the game-core ROM request interface (sdram_req/sdram_addr/sdram_ack/data_dst/data_rdy/data_read) and of the download write interface (prog_addr/prog_data/prog_mask/prog_we).
- Serves each 32-bit read from a 16-bit synchronous memory port using two word reads, and serves download writes as single masked word writes.
- Sits between the game core's ROM slot arbiter and the board memory (BRAM/SDRAM bridge); used for simulation and for SDRAM-less targets.

---
 rtl/jtdd_sdram_resp.sv | 155 +++++++++++++++
 tb/tb_jtdd_sdram_resp.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_sdram_resp.sv
// ROM-request / download-write responder over a 16-bit memory port.
// Each 32-bit read takes two word reads; each download write is one masked word write.
`timescale 1ns/1ps
module jtdd_sdram_resp #(
    parameter int AW  = 22,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic          sdram_req,
    input  logic [AW-1:0] sdram_addr,
    output logic          sdram_ack,
    output logic          data_dst,
    output logic          data_rdy,
    output logic [31:0]   data_read,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [1:0]    prog_mask,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_wmask,
    input  logic [15:0]   mem_dout,
    input  logic          mem_ok
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_DONE,
        S_WR,
        S_GAP
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [1:0]    wmask_n;
    logic [3:0]    gap_cnt, gap_nxt;
    logic          ack_nxt, dst_nxt, rdy_nxt;
    logic          latch_rd, latch_wr, cap_lo, cap_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            addr      <= '0;
            wdata     <= '0;
            wmask_n   <= '0;
            sdram_ack <= 1'b0;
            data_dst  <= 1'b0;
            data_rdy  <= 1'b0;
            data_read <= '0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            sdram_ack <= ack_nxt;
            data_dst  <= dst_nxt;
            data_rdy  <= rdy_nxt;
            if (latch_rd) addr <= sdram_addr;
            if (latch_wr) begin
                addr    <= prog_addr;
                wdata   <= prog_data;
                wmask_n <= prog_mask;
            end
            if (cap_lo) data_read[15:0]  <= mem_dout;
            if (cap_hi) data_read[31:16] <= mem_dout;
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        ack_nxt   = 1'b0;
        dst_nxt   = 1'b0;
        rdy_nxt   = 1'b0;
        latch_rd  = 1'b0;
        latch_wr  = 1'b0;
        cap_lo    = 1'b0;
        cap_hi    = 1'b0;
        case (state)
            S_IDLE: begin
                // Only the request matching the current mode is served
                if (gap_cnt == 4'd0) begin
                    if (!downloading && sdram_req) begin
                        latch_rd  = 1'b1;
                        ack_nxt   = 1'b1;
                        state_nxt = S_RD_LO;
                    end else if (downloading && prog_we) begin
                        latch_wr  = 1'b1;
                        state_nxt = S_WR;
                    end
                end
            end
            S_RD_LO: begin
                if (mem_ok) begin
                    cap_lo    = 1'b1;
                    dst_nxt   = 1'b1;
                    state_nxt = S_RD_HI;
                end
            end
            S_RD_HI: begin
                if (mem_ok) begin
                    cap_hi    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rdy_nxt   = 1'b1;
                gap_nxt   = 4'(GAP);
                state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
            end
            S_WR: begin
                if (mem_ok) begin
                    ack_nxt   = 1'b1;
                    gap_nxt   = 4'(GAP);
                    state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                // Leaving on the final count gives exactly GAP cycles in this state
                if (gap_cnt <= 4'd1) begin
                    gap_nxt   = 4'd0;
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = (state == S_RD_LO) || (state == S_RD_HI);
        mem_we    = (state == S_WR);
        mem_addr  = '0;
        mem_din   = '0;
        mem_wmask = '0;
        case (state)
            S_RD_LO: mem_addr = addr;
            S_RD_HI: mem_addr = addr + AW'(1);
            S_WR: begin
                mem_addr  = addr;
                mem_din   = {wdata, wdata};
                mem_wmask = ~wmask_n;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jtdd_sdram_resp.sv
// Scoreboard bench for jtdd_sdram_resp: client tasks push expectations,
// a negedge monitor pops and compares, and a behavioural memory answers strobes.
`timescale 1ns/1ps
module tb_jtdd_sdram_resp;
    localparam int AW    = 22;
    localparam int GAP_N = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          downloading = 1'b0;
    logic          sdram_req = 1'b0;
    logic [AW-1:0] sdram_addr = '0;
    logic          sdram_ack, data_dst, data_rdy;
    logic [31:0]   data_read;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [7:0]    prog_data = '0;
    logic [1:0]    prog_mask = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_we;
    logic [15:0]   mem_din;
    logic [1:0]    mem_wmask;
    logic [15:0]   mem_dout = '0;
    logic          mem_ok = 1'b0;

    jtdd_sdram_resp #(.AW(AW), .GAP(GAP_N)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_din(mem_din),
        .mem_wmask(mem_wmask), .mem_dout(mem_dout), .mem_ok(mem_ok)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    m;
    } wr_t;

    logic [15:0]   mem_arr [logic [AW-1:0]];
    logic [15:0]   ref_mem [logic [AW-1:0]];
    logic [31:0]   rd_q [$];
    logic [AW-1:0] addr_q [$];
    wr_t           wr_q [$];
    int            ack_pend = 0;

    int dmin = 1, dmax = 1;
    bit lat_chk = 0, gap_chk = 0, have_rdy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic no_expect(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    function automatic logic [15:0] init_word(input logic [AW-1:0] a);
        return 16'hC3A5 ^ a[15:0] ^ {a[7:0], a[15:8]};
    endfunction

    function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Behavioural memory: answers a held strobe after a random delay of at least one cycle.
    initial begin
        int mcnt = 0;
        int mdelay = 1;
        logic [15:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_ok = 1'b0;
                mcnt = 0;
            end else begin
                if (mcnt != 0 && !mem_ok) check("strobe_held", {63'd0, mem_rd | mem_we}, 64'd1);
                if (mem_ok) begin
                    mem_ok = 1'b0;
                    mcnt = (mem_rd || mem_we) ? 1 : 0;
                    mdelay = $urandom_range(dmax, dmin);
                end else if (mem_rd || mem_we) begin
                    if (mcnt == 0) mdelay = $urandom_range(dmax, dmin);
                    mcnt++;
                    if (mcnt > mdelay) begin
                        mem_ok = 1'b1;
                        w = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
                        if (mem_we) begin
                            if (mem_wmask[0]) w[7:0]  = mem_din[7:0];
                            if (mem_wmask[1]) w[15:8] = mem_din[15:8];
                            mem_arr[mem_addr] = w;
                        end else begin
                            mem_dout = w;
                        end
                    end
                end else begin
                    mcnt = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        logic [15:0] exp_lo = '0;
        bit in_rd = 0;
        int ok_rd = 0, ack_cyc = 0, rdy_cyc = 0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rd = 0;
                ok_rd = 0;
                have_rdy = 0;
                continue;
            end
            if (in_rd) check("lo_stable", {48'd0, data_read[15:0]}, {48'd0, exp_lo});
            if (sdram_ack) begin
                if (ack_pend == 0) no_expect("unexpected_ack");
                else ack_pend--;
                if (gap_chk && have_rdy) check("gap_cycles", 64'(cyc - rdy_cyc), 64'd4);
                ack_cyc = cyc;
                ok_rd = 0;
            end
            if (mem_ok && mem_rd) begin
                if (addr_q.size() == 0) no_expect("unexpected_rd");
                else check("rd_addr", {42'd0, mem_addr}, {42'd0, addr_q.pop_front()});
                ok_rd++;
            end
            if (mem_ok && mem_we) begin
                if (wr_q.size() == 0) no_expect("unexpected_wr");
                else begin
                    e = wr_q.pop_front();
                    check("wr_addr", {42'd0, mem_addr}, {42'd0, e.a});
                    check("wr_din", {48'd0, mem_din}, {48'd0, e.d});
                    check("wr_mask", {62'd0, mem_wmask}, {62'd0, e.m});
                end
            end
            if (data_dst) begin
                if (rd_q.size() == 0) no_expect("unexpected_dst");
                else begin
                    exp_lo = rd_q[0][15:0];
                    check("dst_low", {48'd0, data_read[15:0]}, {48'd0, exp_lo});
                    in_rd = 1;
                    if (lat_chk) check("dst_latency", 64'(cyc - ack_cyc), 64'd2);
                end
            end
            if (data_rdy) begin
                if (rd_q.size() == 0) no_expect("unexpected_rdy");
                else check("read_data", {32'd0, data_read}, {32'd0, rd_q.pop_front()});
                check("rdy_after_two_reads", 64'(ok_rd), 64'd2);
                if (lat_chk) check("rdy_latency", 64'(cyc - ack_cyc), 64'd5);
                in_rd = 0;
                rdy_cyc = cyc;
                have_rdy = 1;
            end
        end
    end

    task automatic wait_ack(input string name);
        bit got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sdram_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s: got no ack expected ack within 400 cycles", name);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        logic [AW-1:0] a1;
        a1 = AW'((int'(a) + 1) % (1 << AW));
        @(negedge clk);
        sdram_addr = a;
        sdram_req = 1'b1;
        rd_q.push_back({ref_rd(a1), ref_rd(a)});
        addr_q.push_back(a);
        addr_q.push_back(a1);
        ack_pend++;
        wait_ack("read_ack");
        sdram_req = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] m);
        wr_t e;
        logic [15:0] w;
        @(negedge clk);
        prog_addr = a;
        prog_data = d;
        prog_mask = m;
        prog_we = 1'b1;
        e.a = a;
        e.d = {d, d};
        e.m = {m[1] == 1'b0, m[0] == 1'b0};
        wr_q.push_back(e);
        w = ref_rd(a);
        if (m[0] == 1'b0) w[7:0]  = d;
        if (m[1] == 1'b0) w[15:8] = d;
        ref_mem[a] = w;
        ack_pend++;
        wait_ack("write_ack");
        prog_we = 1'b0;
    endtask

    task automatic wait_quiet();
        bit quiet = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rd_q.size() == 0 && wr_q.size() == 0 && ack_pend == 0) begin
                quiet = 1;
                break;
            end
        end
        if (!quiet) begin
            tests++;
            fails++;
            $display("FAIL quiet_timeout: got %0d pending expected 0", rd_q.size() + wr_q.size() + ack_pend);
        end
        repeat (GAP_N + 2) @(negedge clk);
    endtask

    task automatic set_mode(input logic m);
        if (downloading != m) begin
            sdram_req = 1'b0;
            prog_we = 1'b0;
            wait_quiet();
            @(negedge clk);
            downloading = m;
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [15:0] d);
        mem_arr[a] = d;
        ref_mem[a] = d;
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check("reset_strobes", {58'd0, sdram_ack, data_dst, data_rdy, mem_rd, mem_we, mem_wmask}, 64'd0);
        check("reset_data", {32'd0, data_read}, 64'd0);
        check("reset_addr_din", {26'd0, mem_addr, mem_din}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        lat_chk = 1;
        poke(22'h100, 16'h1234);
        poke(22'h101, 16'hABCD);
        do_read(22'h100);
        wait_quiet();
        check("basic_value", {32'd0, data_read}, 64'hABCD1234);

        poke(22'h0, 16'h5555);
        do_read(22'h3FFFFF);
        wait_quiet();
        check("wrap_hi", {48'd0, data_read[31:16]}, 64'h5555);

        set_mode(1'b1);
        sdram_addr = 22'h123;
        sdram_req = 1'b1;
        do_write(22'h20, 8'h7E, 2'b10);
        do_write(22'h21, 8'h11, 2'b11);
        do_write(22'h22, 8'hA5, 2'b01);
        wait_quiet();
        repeat (20) @(negedge clk);
        set_mode(1'b0);
        do_read(22'h20);
        do_read(22'h22);
        wait_quiet();

        have_rdy = 0;
        gap_chk = 1;
        for (int i = 0; i < 5; i++) do_read(AW'($urandom));
        wait_quiet();
        gap_chk = 0;

        lat_chk = 0;
        dmin = 5;
        dmax = 5;
        do_read(22'h300);
        wait_quiet();

        do_read(22'h200);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == 22'h201) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL rd_hi_timeout: got no RD_HI strobe expected one");
        end
        rst_n = 1'b0;
        #1;
        check("midreset_strobes", {58'd0, sdram_ack, data_dst, data_rdy, mem_rd, mem_we, mem_wmask}, 64'd0);
        check("midreset_data", {32'd0, data_read}, 64'd0);
        check("midreset_addr_din", {26'd0, mem_addr, mem_din}, 64'd0);
        rd_q.delete();
        addr_q.delete();
        wr_q.delete();
        ack_pend = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dmin = 1;
        dmax = 1;
        lat_chk = 1;
        do_read(22'h40);
        wait_quiet();

        lat_chk = 0;
        dmin = 1;
        dmax = 4;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                set_mode(1'b1);
                if ($urandom_range(1, 0) == 1) begin
                    sdram_addr = AW'($urandom);
                    sdram_req = 1'b1;
                end
                do_write(AW'($urandom_range(63, 0)), 8'($urandom), 2'($urandom));
            end else begin
                set_mode(1'b0);
                if ($urandom_range(1, 0) == 1) begin
                    prog_addr = AW'($urandom);
                    prog_we = 1'b1;
                end
                if ($urandom_range(3, 0) == 0) do_read(AW'(22'h3FFFF0 + $urandom_range(15, 0)));
                else do_read(AW'($urandom_range(63, 0)));
            end
        end
        sdram_req = 1'b0;
        prog_we = 1'b0;
        wait_quiet();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
